pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage 16-bit core. Drives the PC enable and the

---
 rtl/core_pkg.sv | 15 +
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: register-file geometry, special opcodes
// and the hazard controller's state encoding.
package core_pkg;

   localparam int          REG_AW   = 3;
   localparam logic [3:0]  HALT_OP  = 4'hF;
   localparam logic [15:0] NOP_INST = 16'h0000;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping; cleared by async reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: post-reset hold, prioritized hazard
// resolution while running, and a sticky HALT, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
   import core_pkg::*;
#(
   parameter int         REG_AW   = core_pkg::REG_AW,
   parameter int         CNT_W    = 16,
   parameter int         HOLD_CYC = 2,
   parameter logic [3:0] HALT_OP  = core_pkg::HALT_OP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        opcodeD,
   input  logic [REG_AW-1:0] rs1D,
   input  logic [REG_AW-1:0] rs2D,
   input  logic [REG_AW-1:0] rdE,
   input  logic              memReadE,
   input  logic              branchTakenE,
   input  logic              imemReady,
   input  logic              dmemReqM,
   input  logic              dmemReady,
   output logic              pcEnable,
   output logic              decEnable,
   output logic              flushD,
   output logic              flushE,
   output logic              stallEM,
   output logic              pcSel,
   output logic              halted,
   output logic [CNT_W-1:0]  stallCnt,
   output logic [CNT_W-1:0]  flushCnt
);

   localparam int             HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYC - 1);

   state_t        state;
   state_t        nextState;
   logic [HW-1:0] holdCnt;
   logic          dmemWait;
   logic          loadUse;
   logic          incStall;
   logic          incFlush;

   assign dmemWait = dmemReqM && !dmemReady;
   assign loadUse  = memReadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= HOLD;
         holdCnt <= '0;
      end else begin
         state <= nextState;
         if ((state == HOLD) && (holdCnt != HOLD_LAST)) begin
            holdCnt <= holdCnt + HW'(1);
         end
      end
   end

   // Rule order matters: a frozen Execute stage must not act on its branch, and a
   // taken branch squashes any wrong-path HALT sitting in Decode.
   always_comb begin
      nextState = state;
      pcEnable  = 1'b0;
      decEnable = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      stallEM   = 1'b0;
      pcSel     = 1'b0;
      halted    = 1'b0;
      incStall  = 1'b0;
      incFlush  = 1'b0;
      case (state)
         HOLD: begin
            flushD = 1'b1;
            flushE = 1'b1;
            if (holdCnt == HOLD_LAST) begin
               nextState = RUN;
            end
         end
         RUN: begin
            if (dmemWait) begin
               stallEM = 1'b1;
            end else if (branchTakenE) begin
               pcSel     = 1'b1;
               pcEnable  = 1'b1;
               decEnable = 1'b1;
               flushD    = 1'b1;
               flushE    = 1'b1;
               incFlush  = 1'b1;
            end else if (opcodeD == HALT_OP) begin
               flushE    = 1'b1;
               nextState = HALT;
            end else if (loadUse) begin
               flushE = 1'b1;
            end else if (!imemReady) begin
               decEnable = 1'b1;
               flushD    = 1'b1;
            end else begin
               pcEnable  = 1'b1;
               decEnable = 1'b1;
            end
            incStall = !pcEnable;
         end
         HALT: begin
            flushE = 1'b1;
            halted = 1'b1;
         end
         default: begin
            nextState = HOLD;
         end
      endcase
   end

   sat_counter #(.W(CNT_W)) stallCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (incStall),
      .cnt   (stallCnt)
   );

   sat_counter #(.W(CNT_W)) flushCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (incFlush),
      .cnt   (flushCnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a cycle-level
// behavioural model of the hold/run/halt rules and saturating counters.
module tb_pipeline_hazard_ctrl;

   localparam int HOLD_CYC = 2;
   localparam int SAT_MAX  = 65535;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  opcodeD;
   logic [2:0]  rs1D, rs2D, rdE;
   logic        memReadE, branchTakenE, imemReady, dmemReqM, dmemReady;
   logic        pcEnable, decEnable, flushD, flushE, stallEM, pcSel, halted;
   logic [15:0] stallCnt, flushCnt;

   int checks   = 0;
   int failures = 0;

   // Model state: remaining hold cycles, sticky halt flag, counter values.
   int holdLeft;
   bit haltM;
   int stallM;
   int flushM;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .opcodeD      (opcodeD),
      .rs1D         (rs1D),
      .rs2D         (rs2D),
      .rdE          (rdE),
      .memReadE     (memReadE),
      .branchTakenE (branchTakenE),
      .imemReady    (imemReady),
      .dmemReqM     (dmemReqM),
      .dmemReady    (dmemReady),
      .pcEnable     (pcEnable),
      .decEnable    (decEnable),
      .flushD       (flushD),
      .flushE       (flushE),
      .stallEM      (stallEM),
      .pcSel        (pcSel),
      .halted       (halted),
      .stallCnt     (stallCnt),
      .flushCnt     (flushCnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [2:0] r1, input logic [2:0] r2,
                                input logic [2:0] rd, input logic mr, input logic br,
                                input logic iRdy, input logic dReq, input logic dRdy);
      opcodeD      = op;
      rs1D         = r1;
      rs2D         = r2;
      rdE          = rd;
      memReadE     = mr;
      branchTakenE = br;
      imemReady    = iRdy;
      dmemReqM     = dReq;
      dmemReady    = dRdy;
   endtask

   task automatic setIdle();
      applyStimulus(4'h1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // Asserts reset mid-cycle, checks the async clear, then releases just after an edge.
   task automatic applyReset(input int cycles);
      reset    = 1'b0;
      holdLeft = HOLD_CYC;
      haltM    = 1'b0;
      stallM   = 0;
      flushM   = 0;
      #1;
      checkOutput("rst_pcEnable", 32'(pcEnable), 32'(0));
      checkOutput("rst_flushD", 32'(flushD), 32'(1));
      checkOutput("rst_halted", 32'(halted), 32'(0));
      checkOutput("rst_stallCnt", 32'(stallCnt), 32'(0));
      checkOutput("rst_flushCnt", 32'(flushCnt), 32'(0));
      repeat (cycles) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // One clock: predict outputs from the rules, compare at negedge, advance model at posedge.
   task automatic stepCycle();
      logic ePc, eDec, eFd, eFe, eSt, eSel, eHalt;
      bit   goHalt;
      bit   running;
      ePc = 0; eDec = 0; eFd = 0; eFe = 0; eSt = 0; eSel = 0; eHalt = 0;
      goHalt  = 0;
      running = (holdLeft == 0) && !haltM;
      if (holdLeft > 0) begin
         eFd = 1; eFe = 1;
      end else if (haltM) begin
         eFe = 1; eHalt = 1;
      end else if (dmemReqM && !dmemReady) begin
         eSt = 1;
      end else if (branchTakenE) begin
         eSel = 1; ePc = 1; eDec = 1; eFd = 1; eFe = 1;
      end else if (opcodeD == 4'hF) begin
         eFe = 1; goHalt = 1;
      end else if (memReadE && rdE != 0 && (rdE == rs1D || rdE == rs2D)) begin
         eFe = 1;
      end else if (!imemReady) begin
         eDec = 1; eFd = 1;
      end else begin
         ePc = 1; eDec = 1;
      end
      @(negedge clk);
      checkOutput("pcEnable", 32'(pcEnable), 32'(ePc));
      checkOutput("decEnable", 32'(decEnable), 32'(eDec));
      checkOutput("flushD", 32'(flushD), 32'(eFd));
      checkOutput("flushE", 32'(flushE), 32'(eFe));
      checkOutput("stallEM", 32'(stallEM), 32'(eSt));
      checkOutput("pcSel", 32'(pcSel), 32'(eSel));
      checkOutput("halted", 32'(halted), 32'(eHalt));
      checkOutput("stallCnt", 32'(stallCnt), 32'(stallM));
      checkOutput("flushCnt", 32'(flushCnt), 32'(flushM));
      @(posedge clk);
      if (running && !ePc && stallM < SAT_MAX) stallM++;
      if (running && eSel && flushM < SAT_MAX) flushM++;
      if (holdLeft > 0) holdLeft--;
      else if (goHalt) haltM = 1;
      #1;
   endtask

   initial begin
      int haltCycles;
      setIdle();

      // T1: hold for two cycles after release, then free-running fetch.
      applyReset(3);
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("T1_run_pcEnable", 32'(pcEnable), 32'(1));

      // T2: load-use on rs2 inserts exactly one bubble.
      applyStimulus(4'h1, 3'd5, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      stepCycle();
      setIdle();
      stepCycle();
      checkOutput("T2_stallCnt", 32'(stallCnt), 32'(1));

      // T3: load into r0 is never a hazard.
      applyStimulus(4'h1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      stepCycle();
      checkOutput("T3_stallCnt", 32'(stallCnt), 32'(1));

      // T4: branch waits behind a data-memory stall, then redirects once.
      applyReset(1);
      repeat (HOLD_CYC) stepCycle();
      applyStimulus(4'h1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) stepCycle();
      dmemReady = 1'b1;
      stepCycle();
      setIdle();
      stepCycle();
      checkOutput("T4_flushCnt", 32'(flushCnt), 32'(1));
      checkOutput("T4_stallCnt", 32'(stallCnt), 32'(3));

      // T5: HALT is sticky until reset; HALT behind a taken branch is squashed.
      applyStimulus(4'hF, 3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      stepCycle();
      branchTakenE = 1'b0;
      stepCycle();
      setIdle();
      repeat (10) stepCycle();
      checkOutput("T5_halted", 32'(halted), 32'(1));
      applyReset(1);
      stepCycle();

      // Randomized run: biased toward hazards, resetting after each HALT.
      haltCycles = 0;
      for (int i = 0; i < 400; i++) begin
         logic [2:0] rd;
         rd = 3'($urandom_range(0, 7));
         applyStimulus(($urandom_range(0, 99) < 4) ? 4'hF : 4'($urandom_range(0, 14)),
                       ($urandom_range(0, 1) == 0) ? rd : 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), rd,
                       1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 15),
                       1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 99) < 30),
                       1'($urandom_range(0, 1)));
         stepCycle();
         haltCycles = haltM ? haltCycles + 1 : 0;
         if (haltCycles >= 4 || $urandom_range(0, 199) == 0) begin
            applyReset(1);
            haltCycles = 0;
         end
      end

      // T6: stall counter saturates at all-ones.
      applyReset(1);
      applyStimulus(4'h1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (HOLD_CYC + SAT_MAX + 5) stepCycle();
      checkOutput("T6_stallCnt_sat", 32'(stallCnt), 32'(16'hFFFF));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
